// File: rtl/bsg_cache_nb_miss_target_queue_pkg.sv
// Shared types and width helpers for the non-blocking cache miss target queue.
// The per-target payload stays opaque here; users pack it themselves.
package bsg_cache_nb_miss_target_queue_pkg;

    typedef enum logic [1:0] {
        e_serve_idle  = 2'd0,
        e_serve_fetch = 2'd1,
        e_serve_serve = 2'd2
    } serve_state_e;

    // Index width that never collapses to zero bits for single-element sets.
    function automatic int lg_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bsg_cache_nb_miss_target_ptrs.sv
// Head/tail/count bookkeeping for one MSHR's circular target FIFO.
// Pointers wrap modulo els_p, so non-power-of-two depths are handled.
module bsg_cache_nb_miss_target_ptrs
    import bsg_cache_nb_miss_target_queue_pkg::*;
#(
    parameter int els_p = 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          enq_i,
    input  logic                          deq_i,
    output logic [lg_min1(els_p)-1:0]     head_o,
    output logic [lg_min1(els_p)-1:0]     head_next_o,
    output logic [lg_min1(els_p)-1:0]     tail_o,
    output logic [cnt_width(els_p)-1:0]   count_o,
    output logic                          ready_o
);

    localparam int pw_lp = lg_min1(els_p);
    localparam int cw_lp = cnt_width(els_p);
    localparam logic [pw_lp-1:0] last_slot_lp = pw_lp'(els_p - 1);

    logic [pw_lp-1:0] head_q, head_d, tail_q, tail_d, tail_next;
    logic [cw_lp-1:0] count_q, count_d;
    logic             enq_ok, deq_ok;

    assign ready_o = (count_q != cw_lp'(els_p));
    assign enq_ok  = enq_i && ready_o;
    assign deq_ok  = deq_i && (count_q != '0);

    always_comb begin
        head_next_o = (head_q == last_slot_lp) ? '0 : head_q + pw_lp'(1);
        tail_next   = (tail_q == last_slot_lp) ? '0 : tail_q + pw_lp'(1);
        head_d      = deq_ok ? head_next_o : head_q;
        tail_d      = enq_ok ? tail_next : tail_q;
        count_d     = count_q;
        if (enq_ok && !deq_ok) begin
            count_d = count_q + cw_lp'(1);
        end else if (deq_ok && !enq_ok) begin
            count_d = count_q - cw_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;

endmodule

// File: rtl/bsg_mem_1r1w_sync.sv
// One-write one-read synchronous RAM; read data is registered (1-cycle latency)
// and holds until the next read. A same-cycle write to the read address is forwarded.
module bsg_mem_1r1w_sync
    import bsg_cache_nb_miss_target_queue_pkg::*;
#(
    parameter int width_p = 1,
    parameter int els_p   = 1
) (
    input  logic                        clk_i,
    input  logic                        w_v_i,
    input  logic [lg_min1(els_p)-1:0]   w_addr_i,
    input  logic [width_p-1:0]          w_data_i,
    input  logic                        r_v_i,
    input  logic [lg_min1(els_p)-1:0]   r_addr_i,
    output logic [width_p-1:0]          r_data_o
);

    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] r_data_q;

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
        if (r_v_i) begin
            r_data_q <= (w_v_i && (w_addr_i == r_addr_i)) ? w_data_i : mem_q[r_addr_i];
        end
    end

    assign r_data_o = r_data_q;

endmodule

// File: rtl/bsg_cache_nb_miss_target_queue.sv
// Per-MSHR read-miss target queues in one shared RAM, drained by a serve engine.
// v_o rises 2 cycles after serve acceptance, then one entry per cycle while yumi_i is held.
module bsg_cache_nb_miss_target_queue
    import bsg_cache_nb_miss_target_queue_pkg::*;
#(
    parameter int entry_width_p  = 1,
    parameter int mshr_els_p     = 1,
    parameter int els_per_mshr_p = 1
) (
    input  logic                                                clk_i,
    input  logic                                                reset_i,
    input  logic                                                enq_v_i,
    input  logic [lg_min1(mshr_els_p)-1:0]                      enq_mshr_id_i,
    input  logic [entry_width_p-1:0]                            enq_data_i,
    output logic [mshr_els_p-1:0]                               ready_o,
    output logic [mshr_els_p-1:0][cnt_width(els_per_mshr_p)-1:0] count_o,
    input  logic                                                serve_v_i,
    input  logic [lg_min1(mshr_els_p)-1:0]                      serve_mshr_id_i,
    output logic                                                serve_ready_o,
    output logic                                                v_o,
    output logic [entry_width_p-1:0]                            data_o,
    output logic [lg_min1(mshr_els_p)-1:0]                      mshr_id_o,
    output logic                                                last_o,
    input  logic                                                yumi_i,
    output logic                                                done_o
);

    localparam int id_w_lp   = lg_min1(mshr_els_p);
    localparam int ptr_w_lp  = lg_min1(els_per_mshr_p);
    localparam int cnt_w_lp  = cnt_width(els_per_mshr_p);
    localparam int mem_els_lp = mshr_els_p * els_per_mshr_p;
    localparam int addr_w_lp = lg_min1(mem_els_lp);

    serve_state_e        state_q, state_d;
    logic [id_w_lp-1:0]  serve_id_q, serve_id_d;

    logic [ptr_w_lp-1:0] head      [mshr_els_p];
    logic [ptr_w_lp-1:0] head_next [mshr_els_p];
    logic [ptr_w_lp-1:0] tail      [mshr_els_p];
    logic [mshr_els_p-1:0] enq_ok, deq;

    logic                 deq_served, enq_to_served;
    logic [ptr_w_lp-1:0]  enq_tail, req_head, srv_head_next;
    logic [cnt_w_lp-1:0]  req_cnt, srv_cnt;
    logic                 r_v;
    logic [addr_w_lp-1:0] r_addr, w_addr;

    function automatic logic [addr_w_lp-1:0] slot_addr(input logic [id_w_lp-1:0]  id,
                                                       input logic [ptr_w_lp-1:0] ptr);
        return addr_w_lp'(id) * addr_w_lp'(els_per_mshr_p) + addr_w_lp'(ptr);
    endfunction

    for (genvar i = 0; i < mshr_els_p; i++) begin : g_mshr
        assign enq_ok[i] = enq_v_i && (enq_mshr_id_i == id_w_lp'(i)) && ready_o[i];
        assign deq[i]    = deq_served && (serve_id_q == id_w_lp'(i));

        bsg_cache_nb_miss_target_ptrs #(
            .els_p(els_per_mshr_p)
        ) ptrs (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .enq_i      (enq_ok[i]),
            .deq_i      (deq[i]),
            .head_o     (head[i]),
            .head_next_o(head_next[i]),
            .tail_o     (tail[i]),
            .count_o    (count_o[i]),
            .ready_o    (ready_o[i])
        );
    end

    always_comb begin
        enq_tail      = '0;
        req_head      = '0;
        req_cnt       = '0;
        srv_head_next = '0;
        srv_cnt       = '0;
        enq_to_served = 1'b0;
        for (int i = 0; i < mshr_els_p; i++) begin
            if (enq_mshr_id_i == id_w_lp'(i)) begin
                enq_tail = tail[i];
            end
            if (serve_mshr_id_i == id_w_lp'(i)) begin
                req_head = head[i];
                req_cnt  = count_o[i];
            end
            if (serve_id_q == id_w_lp'(i)) begin
                srv_head_next = head_next[i];
                srv_cnt       = count_o[i];
                enq_to_served = enq_ok[i];
            end
        end
    end

    assign w_addr = slot_addr(enq_mshr_id_i, enq_tail);

    always_comb begin
        state_d       = state_q;
        serve_id_d    = serve_id_q;
        serve_ready_o = 1'b0;
        v_o           = 1'b0;
        last_o        = 1'b0;
        done_o        = 1'b0;
        deq_served    = 1'b0;
        r_v           = 1'b0;
        r_addr        = '0;
        unique case (state_q)
            e_serve_idle: begin
                serve_ready_o = 1'b1;
                if (serve_v_i) begin
                    if (req_cnt != '0) begin
                        state_d    = e_serve_fetch;
                        serve_id_d = serve_mshr_id_i;
                        r_v        = 1'b1;
                        r_addr     = slot_addr(serve_mshr_id_i, req_head);
                    end else begin
                        done_o = 1'b1;
                    end
                end
            end
            e_serve_fetch: begin
                state_d = e_serve_serve;
            end
            e_serve_serve: begin
                v_o    = 1'b1;
                // A same-cycle append to the served MSHR keeps the drain going.
                last_o = (srv_cnt == cnt_w_lp'(1)) && !enq_to_served;
                if (yumi_i) begin
                    deq_served = 1'b1;
                    if (last_o) begin
                        done_o  = 1'b1;
                        state_d = e_serve_idle;
                    end else begin
                        // Prefetch the next head so it is presented without a bubble;
                        // a just-appended entry arrives via RAM write forwarding.
                        r_v    = 1'b1;
                        r_addr = slot_addr(serve_id_q, srv_head_next);
                    end
                end
            end
            default: begin
                state_d = e_serve_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= e_serve_idle;
            serve_id_q <= '0;
        end else begin
            state_q    <= state_d;
            serve_id_q <= serve_id_d;
        end
    end

    bsg_mem_1r1w_sync #(
        .width_p(entry_width_p),
        .els_p  (mem_els_lp)
    ) mem (
        .clk_i   (clk_i),
        .w_v_i   (|enq_ok),
        .w_addr_i(w_addr),
        .w_data_i(enq_data_i),
        .r_v_i   (r_v),
        .r_addr_i(r_addr),
        .r_data_o(data_o)
    );

    assign mshr_id_o = serve_id_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(enq_v_i && !(|enq_ok)))
                else $warning("enqueue to full MSHR %0d dropped", enq_mshr_id_i);
            assert (!(yumi_i && !v_o))
                else $error("yumi_i asserted without v_o");
        end
    end

endmodule

// File: tb/tb_bsg_cache_nb_miss_target_queue.sv
// Directed bench for the miss target queue: 4 MSHRs of depth 3, 8-bit payloads.
module tb_bsg_cache_nb_miss_target_queue;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic            enq_v_i;
    logic [1:0]      enq_mshr_id_i;
    logic [7:0]      enq_data_i;
    logic [3:0]      ready_o;
    logic [3:0][1:0] count_o;
    logic            serve_v_i;
    logic [1:0]      serve_mshr_id_i;
    logic            serve_ready_o;
    logic            v_o;
    logic [7:0]      data_o;
    logic [1:0]      mshr_id_o;
    logic            last_o;
    logic            yumi_i;
    logic            done_o;

    int tests = 0;
    int fails = 0;

    bsg_cache_nb_miss_target_queue #(
        .entry_width_p (8),
        .mshr_els_p    (4),
        .els_per_mshr_p(3)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .enq_v_i        (enq_v_i),
        .enq_mshr_id_i  (enq_mshr_id_i),
        .enq_data_i     (enq_data_i),
        .ready_o        (ready_o),
        .count_o        (count_o),
        .serve_v_i      (serve_v_i),
        .serve_mshr_id_i(serve_mshr_id_i),
        .serve_ready_o  (serve_ready_o),
        .v_o            (v_o),
        .data_o         (data_o),
        .mshr_id_o      (mshr_id_o),
        .last_o         (last_o),
        .yumi_i         (yumi_i),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic enq_one(input logic [1:0] id, input logic [7:0] d);
        enq_v_i       = 1'b1;
        enq_mshr_id_i = id;
        enq_data_i    = d;
        tick();
        enq_v_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        enq_v_i = 1'b0; enq_mshr_id_i = '0; enq_data_i = '0;
        serve_v_i = 1'b0; serve_mshr_id_i = '0; yumi_i = 1'b0;
        tick(); tick();
        reset_i = 1'b0;
        #1;
        tests++; if (serve_ready_o !== 1'b1) begin fails++; $display("FAIL rst_serve_ready got=%b exp=1", serve_ready_o); end
        tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL rst_v got=%b exp=0", v_o); end
        tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL rst_done got=%b exp=0", done_o); end
        tests++; if (last_o !== 1'b0) begin fails++; $display("FAIL rst_last got=%b exp=0", last_o); end
        tests++; if (ready_o !== 4'b1111) begin fails++; $display("FAIL rst_ready got=%b exp=1111", ready_o); end
        tests++; if (count_o !== 8'h00) begin fails++; $display("FAIL rst_count got=%h exp=00", count_o); end
        tick();
    endtask

    task automatic test_fill();
        enq_one(2'd2, 8'hA1);
        enq_one(2'd2, 8'hB2);
        enq_one(2'd2, 8'hC3);
        #1;
        tests++; if (ready_o !== 4'b1011) begin fails++; $display("FAIL fill_ready got=%b exp=1011", ready_o); end
        tests++; if (count_o[2] !== 2'd3) begin fails++; $display("FAIL fill_count got=%0d exp=3", count_o[2]); end
        tick();
        enq_one(2'd2, 8'hD4);
        #1;
        tests++; if (count_o[2] !== 2'd3) begin fails++; $display("FAIL full_drop_count got=%0d exp=3", count_o[2]); end
        tests++; if (ready_o[2] !== 1'b0) begin fails++; $display("FAIL full_drop_ready got=%b exp=0", ready_o[2]); end
        tick();
    endtask

    task automatic test_serve_full();
        serve_v_i = 1'b1; serve_mshr_id_i = 2'd2;
        #1;
        tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL srv_accept_done got=%b exp=0", done_o); end
        tick();
        serve_v_i = 1'b0;
        #1;
        tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL srv_fetch_v got=%b exp=0", v_o); end
        tests++; if (serve_ready_o !== 1'b0) begin fails++; $display("FAIL srv_fetch_busy got=%b exp=0", serve_ready_o); end
        tick();
        #1;
        tests++; if (v_o !== 1'b1) begin fails++; $display("FAIL srv_v_plus2 got=%b exp=1", v_o); end
        tests++; if (data_o !== 8'hA1) begin fails++; $display("FAIL srv_data_a got=%h exp=a1", data_o); end
        tests++; if (mshr_id_o !== 2'd2) begin fails++; $display("FAIL srv_id got=%0d exp=2", mshr_id_o); end
        tests++; if (last_o !== 1'b0) begin fails++; $display("FAIL srv_last_a got=%b exp=0", last_o); end
        yumi_i = 1'b1;
        tick();
        #1;
        tests++; if (v_o !== 1'b1 || data_o !== 8'hB2) begin fails++; $display("FAIL srv_data_b got=%b/%h exp=1/b2", v_o, data_o); end
        tests++; if (last_o !== 1'b0 || done_o !== 1'b0) begin fails++; $display("FAIL srv_last_b got=%b/%b exp=0/0", last_o, done_o); end
        tick();
        #1;
        tests++; if (v_o !== 1'b1 || data_o !== 8'hC3) begin fails++; $display("FAIL srv_data_c got=%b/%h exp=1/c3", v_o, data_o); end
        tests++; if (last_o !== 1'b1) begin fails++; $display("FAIL srv_last_c got=%b exp=1", last_o); end
        tests++; if (done_o !== 1'b1) begin fails++; $display("FAIL srv_done_c got=%b exp=1", done_o); end
        tick();
        yumi_i = 1'b0;
        #1;
        tests++; if (v_o !== 1'b0 || serve_ready_o !== 1'b1) begin fails++; $display("FAIL srv_idle got=%b/%b exp=0/1", v_o, serve_ready_o); end
        tests++; if (count_o[2] !== 2'd0 || ready_o !== 4'b1111) begin fails++; $display("FAIL srv_drained got=%0d/%b exp=0/1111", count_o[2], ready_o); end
        tick();
    endtask

    task automatic test_enq_during_last();
        enq_one(2'd1, 8'h11);
        serve_v_i = 1'b1; serve_mshr_id_i = 2'd1;
        tick();
        serve_v_i = 1'b0;
        tick();
        #1;
        tests++; if (v_o !== 1'b1 || data_o !== 8'h11 || last_o !== 1'b1) begin fails++; $display("FAIL app_first got=%b/%h/%b exp=1/11/1", v_o, data_o, last_o); end
        enq_v_i = 1'b1; enq_mshr_id_i = 2'd1; enq_data_i = 8'h22;
        yumi_i = 1'b1;
        #1;
        tests++; if (last_o !== 1'b0 || done_o !== 1'b0) begin fails++; $display("FAIL app_nolast got=%b/%b exp=0/0", last_o, done_o); end
        tick();
        enq_v_i = 1'b0;
        #1;
        tests++; if (v_o !== 1'b1 || data_o !== 8'h22) begin fails++; $display("FAIL app_fwd_data got=%b/%h exp=1/22", v_o, data_o); end
        tests++; if (last_o !== 1'b1) begin fails++; $display("FAIL app_last got=%b exp=1", last_o); end
        tests++; if (count_o[1] !== 2'd1) begin fails++; $display("FAIL app_count got=%0d exp=1", count_o[1]); end
        tests++; if (done_o !== 1'b1) begin fails++; $display("FAIL app_done got=%b exp=1", done_o); end
        tick();
        yumi_i = 1'b0;
        #1;
        tests++; if (v_o !== 1'b0 || count_o[1] !== 2'd0) begin fails++; $display("FAIL app_idle got=%b/%0d exp=0/0", v_o, count_o[1]); end
        tick();
    endtask

    task automatic test_serve_empty();
        serve_v_i = 1'b1; serve_mshr_id_i = 2'd3;
        #1;
        tests++; if (done_o !== 1'b1) begin fails++; $display("FAIL empty_done got=%b exp=1", done_o); end
        tests++; if (serve_ready_o !== 1'b1) begin fails++; $display("FAIL empty_ready got=%b exp=1", serve_ready_o); end
        tick();
        serve_v_i = 1'b0;
        #1;
        tests++; if (serve_ready_o !== 1'b1 || v_o !== 1'b0 || done_o !== 1'b0) begin fails++; $display("FAIL empty_after got=%b/%b/%b exp=1/0/0", serve_ready_o, v_o, done_o); end
        tick();
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 5; r++) begin
            logic [7:0] exp_a;
            logic [7:0] exp_b;
            exp_a = 8'h50 + 8'(2 * r);
            exp_b = exp_a + 8'h01;
            enq_one(2'd0, exp_a);
            enq_one(2'd0, exp_b);
            serve_v_i = 1'b1; serve_mshr_id_i = 2'd0;
            tick();
            serve_v_i = 1'b0;
            tick();
            #1;
            tests++; if (v_o !== 1'b1 || data_o !== exp_a || last_o !== 1'b0) begin fails++; $display("FAIL wrap%0d_first got=%b/%h/%b exp=1/%h/0", r, v_o, data_o, last_o, exp_a); end
            yumi_i = 1'b1;
            tick();
            #1;
            tests++; if (v_o !== 1'b1 || data_o !== exp_b || last_o !== 1'b1) begin fails++; $display("FAIL wrap%0d_second got=%b/%h/%b exp=1/%h/1", r, v_o, data_o, last_o, exp_b); end
            tick();
            yumi_i = 1'b0;
        end
        #1;
        tests++; if (count_o[0] !== 2'd0 || serve_ready_o !== 1'b1) begin fails++; $display("FAIL wrap_end got=%0d/%b exp=0/1", count_o[0], serve_ready_o); end
        tick();
    endtask

    task automatic test_reset_mid_serve();
        enq_one(2'd1, 8'h71);
        enq_one(2'd1, 8'h72);
        enq_one(2'd3, 8'h73);
        serve_v_i = 1'b1; serve_mshr_id_i = 2'd1;
        tick();
        serve_v_i = 1'b0;
        tick();
        #1;
        tests++; if (v_o !== 1'b1 || data_o !== 8'h71) begin fails++; $display("FAIL rms_serving got=%b/%h exp=1/71", v_o, data_o); end
        reset_i = 1'b1;
        tick();
        #1;
        tests++; if (v_o !== 1'b0 || done_o !== 1'b0) begin fails++; $display("FAIL rms_v_done got=%b/%b exp=0/0", v_o, done_o); end
        tests++; if (count_o !== 8'h00) begin fails++; $display("FAIL rms_count got=%h exp=00", count_o); end
        tests++; if (ready_o !== 4'b1111) begin fails++; $display("FAIL rms_ready got=%b exp=1111", ready_o); end
        reset_i = 1'b0;
        tick();
        #1;
        tests++; if (serve_ready_o !== 1'b1 || v_o !== 1'b0) begin fails++; $display("FAIL rms_after got=%b/%b exp=1/0", serve_ready_o, v_o); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_serve_full();
        test_enq_during_last();
        test_serve_empty();
        test_wrap();
        test_reset_mid_serve();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bsg_cache_nb_miss_target_queue.md
BSG_CACHE_NB_MISS_TARGET_QUEUE -- requirements
Module: bsg_cache_nb_miss_target_queue

Interface
REQ-001 SHALL have parameter entry_width_p, default none, giving the opaque payload width per read-miss target (src id, offset, masks, partial data packed by the user).
REQ-002 SHALL have parameter mshr_els_p, default none, giving the number of MSHRs, at least 1.
REQ-003 SHALL have parameter els_per_mshr_p, default none, giving the target slots per MSHR, at least 1.
REQ-004 SHALL have ports clk_i (input, 1, clock) and reset_i (input, 1, reset); one clock; reset is synchronous and active-high.
REQ-005 SHALL have port enq_v_i (input, 1): enqueue request.
REQ-006 SHALL have port enq_mshr_id_i (input, lg mshr_els_p): the MSHR for the enqueue.
REQ-007 SHALL have port enq_data_i (input, entry_width_p): the target payload.
REQ-008 SHALL have port ready_o (input/output: output, mshr_els_p): per-MSHR not-full flag.
REQ-009 SHALL have port count_o (output, mshr_els_p x width(els_per_mshr_p)): per-MSHR occupancy.
REQ-010 SHALL have ports serve_v_i (input, 1), serve_mshr_id_i (input, lg mshr_els_p) and serve_ready_o (output, 1, serve engine idle).
REQ-011 SHALL have ports v_o (output, 1), data_o (output, entry_width_p), mshr_id_o (output, lg mshr_els_p), last_o (output, 1) and yumi_i (input, 1).
REQ-012 SHALL have port done_o (output, 1): one-cycle pulse when the MSHR being served is drained.

Function
REQ-013 Each MSHR SHALL own a circular FIFO with head/tail pointers wrapping modulo els_per_mshr_p; this holds for non-power-of-two depths.
REQ-014 Enqueue SHALL occur when enq_v_i and ready_o[enq_mshr_id_i] are both high; count increments and the tail advances.
REQ-015 Enqueue to a full MSHR SHALL be ignored and flagged by a simulation assertion.
REQ-016 ready_o[i] SHALL equal (count_o[i] != els_per_mshr_p).
REQ-017 The FSM SHALL have three states: IDLE, FETCH and SERVE.
REQ-018 In IDLE, serve_ready_o SHALL be 1; serve_v_i with count>0 SHALL latch the id and go to FETCH.
REQ-019 serve_v_i with count==0 SHALL pulse done_o in the same cycle and stay in IDLE.
REQ-020 FETCH SHALL be one cycle of synchronous memory read latency, after which the FSM goes to SERVE with v_o=1; v_o therefore first rises 2 cycles after serve acceptance.
REQ-021 In SERVE, v_o SHALL be 1 and data_o and mshr_id_o SHALL stay stable until yumi_i.
REQ-022 On yumi_i, the head SHALL advance and the count SHALL decrement; if entries remain, the next entry SHALL be presented the following cycle with no bubble, using a prefetch read issued on yumi.
REQ-023 last_o SHALL be 1 when count==1 and there is no enqueue to the served MSHR in this cycle.
REQ-024 yumi_i with last_o=1 SHALL pulse done_o and return the FSM to IDLE in the next cycle.
REQ-025 An enqueue to the served MSHR during SERVE SHALL be permitted and appended; the simultaneous enqueue and yumi of the last entry SHALL keep SERVE with the new entry next cycle, with no done_o.
REQ-026 A read of the slot written in the same cycle SHALL return the newly written data (write-to-read forwarding).
REQ-027 Simultaneous enqueue and dequeue on one MSHR SHALL leave count unchanged.
REQ-028 serve_v_i outside IDLE SHALL be ignored.
REQ-029 yumi_i without v_o SHALL be an assertion error.

Reset
REQ-030 Reset SHALL force FSM=IDLE, all pointers and counts=0, ready_o=all ones, v_o=0, done_o=0, last_o=0 and serve_ready_o=1; data_o is don't-care.
REQ-031 Reset mid-SERVE SHALL discard all queued entries, with no done_o.
REQ-032 Memory contents SHALL not be reset.

Structure
REQ-033 The shared cache package SHALL hold the serve-state enum and width helpers; the payload stays opaque here.
REQ-034 Storage SHALL be one bsg_mem_1r1w_sync with mshr_els_p*els_per_mshr_p entries, addressed mshr_id*els_per_mshr_p+ptr.
REQ-035 Per-MSHR pointer/count logic SHALL be one sub-module, bsg_cache_nb_miss_target_ptrs, replicated by generate.

Verification
REQ-036 mshr_els_p=4, els_per_mshr_p=3: enqueue A,B,C to MSHR2 -> ready_o[2]=0 and count_o[2]=3; a 4th enqueue is dropped.
REQ-037 Serve MSHR2 with yumi held high -> v_o at +2 cycles; A,B,C on consecutive cycles; last_o only with C; done_o on C's yumi.
REQ-038 Serve an MSHR with 1 entry while enqueuing D to it in the same cycle as its yumi -> no done_o; D presented next cycle, last_o=1.
REQ-039 Serve an empty MSHR -> done_o in the same cycle; serve_ready_o remains 1.
REQ-040 Wrap-around: 5 enqueue/serve rounds of 2 entries on depth 3 -> data order preserved.
REQ-041 Assert reset_i mid-SERVE -> next cycle v_o=0, count_o all 0 and ready_o all 1.
